// File: rtl/mem_pkg.sv
// Frame buffer addressing: width and type of a frame start pointer.
package mem_pkg;

    localparam int ADDR_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/switch_pkg.sv
// Switch-wide sizing shared by the egress path: port count, queue depth and
// the occupancy counter width derived from it.
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int VOQ_DEPTH = 8;
    localparam int CNT_W     = $clog2(VOQ_DEPTH + 1);

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/voq_fifo.sv
// One first-word-fall-through pointer FIFO for a single egress port, with
// occupancy count, full flag and a one-cycle drop pulse for rejected enqueues.
module voq_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req_i,
    input  addr_t            push_ptr_i,
    input  logic             pop_ready_i,
    output logic             valid_o,
    output addr_t            head_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o,
    output logic             drop_o
);

    localparam int PTR_W = $clog2(DEPTH);

    addr_t            mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             full, valid, push, pop;

    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    always_comb begin
        full   = (cnt_q == CNT_W'(DEPTH));
        valid  = (cnt_q != '0);
        pop    = valid & pop_ready_i;
        push   = push_req_i & (~full | pop);
        drop_d = push_req_i & full & ~pop;
        rd_d   = pop  ? rd_q + PTR_W'(1) : rd_q;
        wr_d   = push ? wr_q + PTR_W'(1) : wr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= push_ptr_i;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Outputs come straight from state; the head is stale (don't-care) when empty.
    assign valid_o = valid;
    assign head_o  = mem_q[rd_q];
    assign full_o  = full;
    assign count_o = cnt_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/voq_bank.sv
// Bank of independent per-egress-port pointer queues fed by the crossbar.
// Optional per-queue saturating drop counters are enabled with VOQ_STATS_EN.
module voq_bank
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
    parameter int VOQ_DEPTH = switch_pkg::VOQ_DEPTH,
    parameter int CNT_W     = $clog2(VOQ_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              voq_write_reqs_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  voq_start_ptrs_i,
    output logic [NUM_PORTS-1:0]              deq_valid_o,
    output logic [NUM_PORTS-1:0][ADDR_W-1:0]  deq_ptr_o,
    input  logic [NUM_PORTS-1:0]              deq_ready_i,
    output logic [NUM_PORTS-1:0]              voq_full_o,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]   voq_count_o,
    output logic [NUM_PORTS-1:0]              drop_o
`ifdef VOQ_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][15:0]        drop_cnt_o
`endif
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_queue
        voq_fifo #(
            .DEPTH (VOQ_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_req_i  (voq_write_reqs_i[p]),
            .push_ptr_i  (voq_start_ptrs_i[p]),
            .pop_ready_i (deq_ready_i[p]),
            .valid_o     (deq_valid_o[p]),
            .head_o      (deq_ptr_o[p]),
            .full_o      (voq_full_o[p]),
            .count_o     (voq_count_o[p]),
            .drop_o      (drop_o[p])
        );
    end

`ifdef VOQ_STATS_EN
    logic [NUM_PORTS-1:0][15:0] drop_cnt_q, drop_cnt_d;

    // Counts the registered drop pulses, so each counter trails its pulse by one cycle.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (drop_o[p] && (drop_cnt_q[p] != 16'hFFFF))
                drop_cnt_d[p] = drop_cnt_q[p] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_voq_bank.sv
// Directed bench for voq_bank with a per-queue scoreboard of expected pointers.
// Build with VOQ_STATS_EN to also check the drop counters.
module tb_voq_bank;
    import switch_pkg::*;
    import mem_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic [NUM_PORTS-1:0]              wrReq = '0;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  ptrs = '0;
    logic [NUM_PORTS-1:0]              deqReady = '0;
    logic [NUM_PORTS-1:0]              deqValid;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  deqPtr;
    logic [NUM_PORTS-1:0]              voqFull;
    logic [NUM_PORTS-1:0][CNT_W-1:0]   voqCount;
    logic [NUM_PORTS-1:0]              drop;
`ifdef VOQ_STATS_EN
    logic [NUM_PORTS-1:0][15:0]        dropCnt;
`endif

    addr_t                sbq [NUM_PORTS][$];
    logic [NUM_PORTS-1:0] expDrop = '0;
    int                   expDropCnt [NUM_PORTS];
    addr_t                lastPop [NUM_PORTS];
    int                   checks = 0;
    int                   errors = 0;

    always #5 clk = ~clk;

    voq_bank dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .voq_write_reqs_i (wrReq),
        .voq_start_ptrs_i (ptrs),
        .deq_valid_o      (deqValid),
        .deq_ptr_o        (deqPtr),
        .deq_ready_i      (deqReady),
        .voq_full_o       (voqFull),
        .voq_count_o      (voqCount),
        .drop_o           (drop)
`ifdef VOQ_STATS_EN
        ,
        .drop_cnt_o       (dropCnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < NUM_PORTS; i++) begin
            int sz = sbq[i].size();
            chk($sformatf("valid[%0d]", i), 32'(deqValid[i]), 32'(sz != 0));
            chk($sformatf("count[%0d]", i), 32'(voqCount[i]), 32'(sz));
            chk($sformatf("full[%0d]", i),  32'(voqFull[i]),  32'(sz == VOQ_DEPTH));
            chk($sformatf("drop[%0d]", i),  32'(drop[i]),     32'(expDrop[i]));
            if (sz != 0) chk($sformatf("head[%0d]", i), 32'(deqPtr[i]), 32'(sbq[i][0]));
`ifdef VOQ_STATS_EN
            chk($sformatf("dropCnt[%0d]", i), 32'(dropCnt[i]), 32'(expDropCnt[i]));
`endif
        end
    endtask

    // Drives one cycle of inputs, updates the model and checks the state after the edge.
    task automatic applyStimulus(input logic [NUM_PORTS-1:0] wr,
                                 input logic [NUM_PORTS-1:0][ADDR_W-1:0] p,
                                 input logic [NUM_PORTS-1:0] rdy);
        logic [NUM_PORTS-1:0] dropNext;
        dropNext = '0;
        wrReq = wr;
        ptrs = p;
        deqReady = rdy;
        #1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int  sz = sbq[i].size();
            bit  pop = (sz != 0) && rdy[i];
            bit  full = (sz == VOQ_DEPTH);
            bit  push = wr[i] && (!full || pop);
            if (pop) begin
                chk($sformatf("popPtr[%0d]", i), 32'(deqPtr[i]), 32'(sbq[i][0]));
                lastPop[i] = sbq[i].pop_front();
            end
            if (push) sbq[i].push_back(p[i]);
            dropNext[i] = wr[i] && full && !pop;
        end
        @(posedge clk);
        #1;
        wrReq = '0;
        deqReady = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (expDrop[i] && expDropCnt[i] < 65535) expDropCnt[i]++;
        expDrop = dropNext;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus('0, '0, '0);
    endtask

    task automatic pushOne(input int port, input addr_t val, input bit rdy);
        logic [NUM_PORTS-1:0][ADDR_W-1:0] p;
        logic [NUM_PORTS-1:0] w, r;
        p = '0; w = '0; r = '0;
        p[port] = val;
        w[port] = 1'b1;
        r[port] = rdy;
        applyStimulus(w, p, r);
    endtask

    task automatic drain(input logic [NUM_PORTS-1:0] mask);
        for (int k = 0; k < VOQ_DEPTH + 2; k++) applyStimulus('0, '0, mask);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, ".valid"}, 32'(deqValid), 32'h0);
        chk({tag, ".ptr"},   32'(deqPtr[0] | deqPtr[1] | deqPtr[2] | deqPtr[3]), 32'h0);
        chk({tag, ".full"},  32'(voqFull), 32'h0);
        chk({tag, ".count"}, 32'(voqCount), 32'h0);
        chk({tag, ".drop"},  32'(drop), 32'h0);
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_PORTS; i++) begin
            sbq[i].delete();
            expDropCnt[i] = 0;
        end
        expDrop = '0;
    endtask

    initial begin
        clearModel();
        #12;
        checkAllZero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();

        // Single push and pop on q0
        pushOne(0, 16'h0010, 1'b0);
        chk("t1.ptr", 32'(deqPtr[0]), 32'h10);
        chk("t1.count", 32'(voqCount[0]), 32'd1);
        applyStimulus('0, '0, 4'b0001);
        chk("t1.validAfterPop", 32'(deqValid[0]), 32'd0);
        applyStimulus('0, '0, 4'b0001);

        // Flood write into every queue
        applyStimulus(4'b1111, {4{16'h0020}}, '0);
        for (int i = 0; i < NUM_PORTS; i++)
            chk($sformatf("t2.ptr[%0d]", i), 32'(deqPtr[i]), 32'h20);
        drain(4'b1111);

        // Fill q1, overflow once, then drain in order
        for (int v = 1; v <= 8; v++) pushOne(1, addr_t'(v), 1'b0);
        chk("t3.full", 32'(voqFull[1]), 32'd1);
        pushOne(1, 16'h0009, 1'b0);
        chk("t3.drop", 32'(drop[1]), 32'd1);
        chk("t3.count", 32'(voqCount[1]), 32'd8);
        idle();
        drain(4'b0010);
        chk("t3.last", 32'(lastPop[1]), 32'h08);

        // Full q2 with simultaneous push and pop
        for (int v = 0; v < 8; v++) pushOne(2, addr_t'(16'h40 + v), 1'b0);
        pushOne(2, 16'h0030, 1'b1);
        chk("t4.noDrop", 32'(drop[2]), 32'd0);
        chk("t4.count", 32'(voqCount[2]), 32'd8);
        drain(4'b0100);
        chk("t4.last", 32'(lastPop[2]), 32'h30);

        // Pointer wrap on q3 with interleaved traffic
        for (int v = 0; v < 20; v++) begin
            pushOne(3, addr_t'(v), (v % 3) != 0);
            chk("t5.bound", 32'(voqCount[3] <= CNT_W'(VOQ_DEPTH)), 32'd1);
        end
        drain(4'b1000);
        chk("t5.last", 32'(lastPop[3]), 32'h13);

        // Async reset in the middle of traffic
        for (int v = 0; v < 5; v++) pushOne(0, addr_t'(16'h50 + v), 1'b0);
        chk("t6.pre", 32'(voqCount[0]), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("t6.async");
        clearModel();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();
        for (int v = 0; v < 8; v++) pushOne(1, addr_t'(16'h60 + v), 1'b0);
        for (int v = 0; v < 3; v++) pushOne(1, 16'h0070, 1'b0);
        idle();
        idle();
`ifdef VOQ_STATS_EN
        chk("t6.dropCnt", 32'(dropCnt[1]), 32'd3);
`endif
        drain(4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
